// File: rtl/react_trial_ctrl.sv
// Reaction-time trial controller.
// A start request arms a pseudo-random pre-stimulus delay. The stimulus LED is
// then lit and the time to the first button press is measured in milliseconds.
// A press during the delay is a false start, and no press within the limit is
// an overflow.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | waiting for start; results from the last trial are held
// DELAY  | counting ms up to the latched random target; LED off
// ARMED  | LED on; counting ms until a press or the timeout limit
// RESULT | single cycle; done pulses and the results are valid
module react_trial_ctrl #(
   parameter int         CLK_PER_MS   = 12000,
   parameter int         MIN_DELAY_MS = 1000,
   parameter logic [9:0] DELAY_MASK   = 10'h3FF,
   parameter int         TIMEOUT_MS   = 999
) (
   input  logic       clk,
   input  logic       rstn,
   input  logic       start,
   input  logic       abort,
   input  logic       btn,
   output logic       stimulus,
   output logic       busy,
   output logic       done,
   output logic [9:0] react_time,
   output logic       overflow,
   output logic       false_start,
   output logic [2:0] state
);

   localparam int PW = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;
   localparam logic [PW-1:0] PRESC_MAX   = PW'(CLK_PER_MS - 1);
   localparam logic [10:0]   TIMEOUT_CNT = 11'(TIMEOUT_MS);
   localparam logic [9:0]    TIMEOUT_RT  = 10'(TIMEOUT_MS);
   localparam logic [15:0]   LFSR_SEED   = 16'hACE1;
   localparam logic [15:0]   LFSR_TAPS   = 16'hB400;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_DELAY  = 3'd1,
      S_ARMED  = 3'd2,
      S_RESULT = 3'd3
   } state_t;

   state_t        state_q, state_d;
   logic          btn_q;
   logic [15:0]   lfsr_q;
   logic [PW-1:0] presc_q, presc_d;
   logic [10:0]   ms_q, ms_d;
   logic [10:0]   target_q, target_d;
   logic [9:0]    rt_d;
   logic          ov_d, fs_d;

   logic          press, tick, delay_hit, timeout_hit;
   logic [10:0]   ms_inc;

   // A held button never re-triggers: only the low-to-high transition counts.
   assign press       = btn & ~btn_q;
   assign tick        = ((state_q == S_DELAY) || (state_q == S_ARMED)) && (presc_q == PRESC_MAX);
   assign ms_inc      = ms_q + 11'd1;
   assign delay_hit   = tick && (ms_inc == target_q);
   assign timeout_hit = tick && (ms_inc == TIMEOUT_CNT);
   assign state       = state_q;

   // State register.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   // Next-state logic; abort outranks press, and press outranks any tick.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (start) state_d = S_DELAY;
         end
         S_DELAY: begin
            if (abort)          state_d = S_IDLE;
            else if (press)     state_d = S_RESULT;
            else if (delay_hit) state_d = S_ARMED;
         end
         S_ARMED: begin
            if (abort)                     state_d = S_IDLE;
            else if (press || timeout_hit) state_d = S_RESULT;
         end
         S_RESULT: state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   // Datapath and result next values, registered below together with the flags.
   always_comb begin
      presc_d  = presc_q;
      ms_d     = ms_q;
      target_d = target_q;
      rt_d     = react_time;
      ov_d     = overflow;
      fs_d     = false_start;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               target_d = 11'(MIN_DELAY_MS) + {1'b0, lfsr_q[9:0] & DELAY_MASK};
               rt_d     = '0;
               ov_d     = 1'b0;
               fs_d     = 1'b0;
               presc_d  = '0;
               ms_d     = '0;
            end
         end
         S_DELAY: begin
            if (!abort) begin
               if (press) begin
                  fs_d = 1'b1;
                  rt_d = TIMEOUT_RT;
                  ov_d = 1'b0;
               end else if (tick) begin
                  presc_d = '0;
                  ms_d    = delay_hit ? 11'd0 : ms_inc;
               end else begin
                  presc_d = presc_q + 1'b1;
               end
            end
         end
         S_ARMED: begin
            if (!abort) begin
               if (press) begin
                  // A press on the timeout tick is still a valid reaction at the limit.
                  rt_d = timeout_hit ? TIMEOUT_RT : ms_q[9:0];
                  ov_d = 1'b0;
               end else if (timeout_hit) begin
                  rt_d = TIMEOUT_RT;
                  ov_d = 1'b1;
               end else if (tick) begin
                  presc_d = '0;
                  ms_d    = ms_inc;
               end else begin
                  presc_d = presc_q + 1'b1;
               end
            end
         end
         default: ;
      endcase
   end

   // Registered datapath, LFSR, button history and outputs.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         btn_q       <= 1'b0;
         lfsr_q      <= LFSR_SEED;
         presc_q     <= '0;
         ms_q        <= '0;
         target_q    <= '0;
         react_time  <= '0;
         overflow    <= 1'b0;
         false_start <= 1'b0;
         stimulus    <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
      end else begin
         btn_q       <= btn;
         lfsr_q      <= lfsr_q[0] ? ((lfsr_q >> 1) ^ LFSR_TAPS) : (lfsr_q >> 1);
         presc_q     <= presc_d;
         ms_q        <= ms_d;
         target_q    <= target_d;
         react_time  <= rt_d;
         overflow    <= ov_d;
         false_start <= fs_d;
         stimulus    <= (state_d == S_ARMED);
         busy        <= (state_d != S_IDLE);
         done        <= (state_d == S_RESULT);
      end
   end

endmodule

// File: tb/tb_react_trial_ctrl.sv
// Directed bench for react_trial_ctrl with small timing parameters
// (4 clk per ms, 3 ms delay, no random part, 9 ms limit).
module tb_react_trial_ctrl;

   logic       clk = 1'b0;
   logic       rstn, start, abort, btn;
   logic       stimulus, busy, done, overflow, false_start;
   logic [9:0] react_time;
   logic [2:0] state;

   int vectors = 0;
   int miscompares = 0;

   react_trial_ctrl #(
      .CLK_PER_MS(4), .MIN_DELAY_MS(3), .DELAY_MASK(10'h000), .TIMEOUT_MS(9)
   ) dut (
      .clk(clk), .rstn(rstn), .start(start), .abort(abort), .btn(btn),
      .stimulus(stimulus), .busy(busy), .done(done), .react_time(react_time),
      .overflow(overflow), .false_start(false_start), .state(state)
   );

   always #5 clk = ~clk;

   wire [17:0] snap = {state, stimulus, busy, done, overflow, false_start, react_time};

   function automatic logic [17:0] pack(input logic [2:0] st, input logic stim, input logic bsy,
                                        input logic dn, input logic ov, input logic fs,
                                        input logic [9:0] rt);
      return {st, stim, bsy, dn, ov, fs, rt};
   endfunction

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic pulse_start();
      start = 1'b1;
      step(1);
      start = 1'b0;
   endtask

   task automatic test_reset();
      logic [17:0] e;
      rstn = 1'b0; start = 1'b0; abort = 1'b0; btn = 1'b0;
      #2;
      e = pack(0, 0, 0, 0, 0, 0, 0);
      vectors++; if (snap !== e) begin miscompares++; $display("FAIL reset_state got=%h exp=%h", snap, e); end
      #10 rstn = 1'b1;
      step(2);
   endtask

   task automatic test_normal();
      logic [17:0] e;
      pulse_start();
      e = pack(1, 0, 1, 0, 0, 0, 0);
      vectors++; if (snap !== e) begin miscompares++; $display("FAIL normal_delay_entry got=%h exp=%h", snap, e); end
      step(11);
      vectors++; if (snap !== e) begin miscompares++; $display("FAIL normal_delay_last got=%h exp=%h", snap, e); end
      step(1);
      e = pack(2, 1, 1, 0, 0, 0, 0);
      vectors++; if (snap !== e) begin miscompares++; $display("FAIL normal_armed got=%h exp=%h", snap, e); end
      step(16);
      btn = 1'b1;
      step(1);
      e = pack(3, 0, 1, 1, 0, 0, 4);
      vectors++; if (snap !== e) begin miscompares++; $display("FAIL normal_result got=%h exp=%h", snap, e); end
      step(1);
      btn = 1'b0;
      e = pack(0, 0, 0, 0, 0, 0, 4);
      vectors++; if (snap !== e) begin miscompares++; $display("FAIL normal_hold got=%h exp=%h", snap, e); end
      step(1);
   endtask

   task automatic test_timeout();
      logic [17:0] e;
      int cnt;
      pulse_start();
      step(12);
      e = pack(2, 1, 1, 0, 0, 0, 0);
      vectors++; if (snap !== e) begin miscompares++; $display("FAIL timeout_armed got=%h exp=%h", snap, e); end
      cnt = 0;
      while (stimulus === 1'b1 && cnt < 100) begin
         cnt++;
         step(1);
      end
      vectors++; if (cnt !== 36) begin miscompares++; $display("FAIL timeout_stim_cycles got=%0d exp=36", cnt); end
      e = pack(3, 0, 1, 1, 1, 0, 9);
      vectors++; if (snap !== e) begin miscompares++; $display("FAIL timeout_result got=%h exp=%h", snap, e); end
      step(1);
      e = pack(0, 0, 0, 0, 1, 0, 9);
      vectors++; if (snap !== e) begin miscompares++; $display("FAIL timeout_hold got=%h exp=%h", snap, e); end
   endtask

   task automatic test_press_edges();
      logic [17:0] e;
      // press on the very tick that would time out
      pulse_start();
      step(12 + 35);
      btn = 1'b1;
      step(1);
      e = pack(3, 0, 1, 1, 0, 0, 9);
      vectors++; if (snap !== e) begin miscompares++; $display("FAIL press_on_timeout got=%h exp=%h", snap, e); end
      step(1);
      btn = 1'b0;
      step(1);
      // press one cycle before the final tick
      pulse_start();
      step(12 + 34);
      btn = 1'b1;
      step(1);
      e = pack(3, 0, 1, 1, 0, 0, 8);
      vectors++; if (snap !== e) begin miscompares++; $display("FAIL press_before_timeout got=%h exp=%h", snap, e); end
      step(1);
      btn = 1'b0;
      step(1);
   endtask

   task automatic test_false_start();
      logic [17:0] e;
      pulse_start();
      step(5);
      btn = 1'b1;
      step(1);
      e = pack(3, 0, 1, 1, 0, 1, 9);
      vectors++; if (snap !== e) begin miscompares++; $display("FAIL false_start_mid got=%h exp=%h", snap, e); end
      step(1);
      btn = 1'b0;
      e = pack(0, 0, 0, 0, 0, 1, 9);
      vectors++; if (snap !== e) begin miscompares++; $display("FAIL false_start_hold got=%h exp=%h", snap, e); end
      pulse_start();
      e = pack(1, 0, 1, 0, 0, 0, 0);
      vectors++; if (snap !== e) begin miscompares++; $display("FAIL start_clears_results got=%h exp=%h", snap, e); end
      step(11);
      btn = 1'b1;
      step(1);
      e = pack(3, 0, 1, 1, 0, 1, 9);
      vectors++; if (snap !== e) begin miscompares++; $display("FAIL false_start_on_target got=%h exp=%h", snap, e); end
      step(1);
      btn = 1'b0;
      step(1);
   endtask

   task automatic test_held_btn();
      logic [17:0] e;
      btn = 1'b1;
      step(2);
      pulse_start();
      step(12);
      e = pack(2, 1, 1, 0, 0, 0, 0);
      vectors++; if (snap !== e) begin miscompares++; $display("FAIL held_btn_armed got=%h exp=%h", snap, e); end
      btn = 1'b0;
      step(8);
      btn = 1'b1;
      step(1);
      e = pack(3, 0, 1, 1, 0, 0, 2);
      vectors++; if (snap !== e) begin miscompares++; $display("FAIL held_btn_result got=%h exp=%h", snap, e); end
      step(1);
      btn = 1'b0;
      step(1);
   endtask

   task automatic test_abort();
      logic [17:0] e;
      logic seen_done;
      pulse_start();
      step(12 + 3);
      start = 1'b1;
      step(1);
      start = 1'b0;
      e = pack(2, 1, 1, 0, 0, 0, 0);
      vectors++; if (snap !== e) begin miscompares++; $display("FAIL start_ignored_armed got=%h exp=%h", snap, e); end
      abort = 1'b1;
      btn = 1'b1;
      step(1);
      abort = 1'b0;
      e = pack(0, 0, 0, 0, 0, 0, 0);
      vectors++; if (snap !== e) begin miscompares++; $display("FAIL abort_armed got=%h exp=%h", snap, e); end
      seen_done = 1'b0;
      for (int i = 0; i < 4; i++) begin
         step(1);
         if (done === 1'b1) seen_done = 1'b1;
      end
      vectors++; if (seen_done !== 1'b0) begin miscompares++; $display("FAIL abort_no_done got=%b exp=0", seen_done); end
      btn = 1'b0;
      step(1);
      pulse_start();
      step(4);
      abort = 1'b1;
      step(1);
      abort = 1'b0;
      vectors++; if (snap !== e) begin miscompares++; $display("FAIL abort_delay got=%h exp=%h", snap, e); end
      step(1);
   endtask

   task automatic test_reset_mid();
      logic [17:0] e;
      pulse_start();
      step(12 + 5);
      #3 rstn = 1'b0;
      #1;
      e = pack(0, 0, 0, 0, 0, 0, 0);
      vectors++; if (snap !== e) begin miscompares++; $display("FAIL reset_mid_armed got=%h exp=%h", snap, e); end
      #2 rstn = 1'b1;
      step(3);
      vectors++; if (snap !== e) begin miscompares++; $display("FAIL reset_mid_after got=%h exp=%h", snap, e); end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_normal();
      test_timeout();
      test_press_edges();
      test_false_start();
      test_held_btn();
      test_abort();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
